crc32_stream: RTL and testbench

CRC32_STREAM -- requirements
Module: crc32_stream

---
 rtl/crc_pkg.sv | 38 +++
 rtl/crc32_stream_if.sv | 43 ++++
 rtl/crc32_byte_update.sv | 30 +++
 rtl/crc32_stream.sv | 118 +++++++++++
 tb/tb_crc32_stream.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the Ethernet CRC-32 stream engine: CRC constants,
// the byte / CRC word types carried on the stream, and the engine state
// encoding. No ports; imported by every other file of the block.
// -----------------------------------------------------------------------------
package crc_pkg;

    localparam int CRC_WIDTH = 32;

    typedef logic [CRC_WIDTH-1:0] crc_t;
    typedef logic [7:0]           byte_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    localparam crc_t POLY        = 32'h04C11DB7;
    localparam crc_t CRC_INIT    = 32'hFFFFFFFF;
    localparam crc_t CRC_XOROUT  = 32'hFFFFFFFF;
    localparam crc_t CRC_RESIDUE = 32'hDEBB20E3;

    // Bit-reverse a CRC word; used to derive the LSB-first polynomial.
    function automatic crc_t reflect32(input crc_t v);
        crc_t r;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            r[i] = v[CRC_WIDTH-1-i];
        end
        return r;
    endfunction

    // Reflected-in/out CRC shifts LSB first, so the register works with the
    // bit-reversed polynomial (0xEDB88320).
    localparam crc_t POLY_REFL = reflect32(POLY);

endpackage

// File: rtl/crc32_stream_if.sv
// -----------------------------------------------------------------------------
// crc32_stream_if
// Bundles the byte stream input (s_*) and the CRC result output (m_*) of
// crc32_stream.
//   s_data  [DATA_WIDTH]  stream data, lane i = bits [8i+7:8i], lane 0 first
//   s_keep  [DATA_BYTES]  per-lane byte valid
//   s_valid / s_ready     beat handshake
//   s_last                final beat of frame
//   m_crc   [32]          final CRC, bits [7:0] transmitted first
//   m_crc_ok              residue check passed (frame + FCS error-free)
//   m_valid / m_ready     result handshake
// Modports: master = stream source / result sink, slave = CRC engine.
// -----------------------------------------------------------------------------
interface crc32_stream_if
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    localparam int DATA_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] s_data;
    logic [DATA_BYTES-1:0] s_keep;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    crc_t                  m_crc;
    logic                  m_crc_ok;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output s_data, s_keep, s_valid, s_last, m_ready,
        input  s_ready, m_crc, m_crc_ok, m_valid
    );

    modport slave (
        input  s_data, s_keep, s_valid, s_last, m_ready,
        output s_ready, m_crc, m_crc_ok, m_valid
    );

endinterface

// File: rtl/crc32_byte_update.sv
// -----------------------------------------------------------------------------
// crc32_byte_update
// Combinational one-byte step of the reflected Ethernet CRC-32.
//   crc_in   [32]  running CRC register value
//   data     [8]   byte to fold in
//   en             1 = fold the byte in, 0 = pass crc_in through unchanged
//   crc_out  [32]  updated CRC
// -----------------------------------------------------------------------------
module crc32_byte_update
    import crc_pkg::*;
(
    input  crc_t  crc_in,
    input  byte_t data,
    input  logic  en,
    output crc_t  crc_out
);

    crc_t crc_upd;

    always_comb begin
        // Reflected input: the byte enters at the LSB end and is shifted
        // out first.
        crc_upd = crc_in ^ {{(CRC_WIDTH-8){1'b0}}, data};
        for (int b = 0; b < 8; b++) begin
            crc_upd = crc_upd[0] ? ((crc_upd >> 1) ^ POLY_REFL) : (crc_upd >> 1);
        end
        crc_out = en ? crc_upd : crc_in;
    end

endmodule

// File: rtl/crc32_stream.sv
// -----------------------------------------------------------------------------
// crc32_stream
// Streaming Ethernet CRC-32 (FCS) generator / checker. Folds in up to
// DATA_BYTES bytes per clock and presents one result per frame.
//   i_clk      clock, all logic on rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        crc32_stream_if.slave (stream in, result out)
// DATA_WIDTH: 32 or 64.
// -----------------------------------------------------------------------------
module crc32_stream
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    crc32_stream_if.slave      bus
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;

    state_t state;
    state_t state_next;
    crc_t   crc_reg;
    crc_t   crc_next;
    crc_t   crc_out_reg;
    logic   crc_ok_reg;
    logic   ready_en;
    logic   accept;
    logic   last_accept;

    // Lane chain: lane 0 sees the register, each later lane sees its
    // predecessor, so enabled lanes are folded in ascending order and
    // cleared lanes are transparent.
    for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane
        crc_t lane_in;
        crc_t lane_out;

        if (i == 0) begin : g_first
            assign lane_in = crc_reg;
        end else begin : g_next
            assign lane_in = g_lane[i-1].lane_out;
        end

        crc32_byte_update u_update (
            .crc_in  (lane_in),
            .data    (bus.s_data[8*i +: 8]),
            .en      (bus.s_keep[i]),
            .crc_out (lane_out)
        );
    end

    assign crc_next = g_lane[DATA_BYTES-1].lane_out;

    // ready_en keeps s_ready low during reset and raises it on the first
    // edge after release. In HOLD the result slot is only freed when the
    // consumer takes it, so input is throttled to m_ready.
    assign bus.s_ready = ready_en && ((state != ST_HOLD) || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_accept = accept && bus.s_last;

    assign bus.m_valid  = (state == ST_HOLD);
    assign bus.m_crc    = crc_out_reg;
    assign bus.m_crc_ok = crc_ok_reg;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_next = bus.s_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                // An accepted beat here implies m_ready, so the current
                // result is consumed on the same edge.
                if (accept) begin
                    state_next = bus.s_last ? ST_HOLD : ST_ACCUM;
                end else if (bus.m_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    // ---- accumulate stage: running CRC, reloaded as the frame closes ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_reg <= CRC_INIT;
        end else if (accept) begin
            crc_reg <= bus.s_last ? CRC_INIT : crc_next;
        end
    end

    // ---- result stage: only written on a closing beat, so it stays put
    // while the consumer stalls ----
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_out_reg <= '0;
            crc_ok_reg  <= 1'b0;
        end else if (last_accept) begin
            crc_out_reg <= crc_next ^ CRC_XOROUT;
            crc_ok_reg  <= (crc_next == CRC_RESIDUE);
        end
    end

endmodule

// File: tb/tb_crc32_stream.sv
module tb_crc32_stream;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b1;

    always #5 i_clk = ~i_clk;

    crc32_stream_if #(.DATA_WIDTH(32)) a32 ();
    crc32_stream_if #(.DATA_WIDTH(64)) a64 ();

    crc32_stream #(.DATA_WIDTH(32)) dut32 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (a32.slave)
    );

    crc32_stream #(.DATA_WIDTH(64)) dut64 (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (a64.slave)
    );

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    logic [31:0] run32 = 32'hFFFFFFFF;
    logic [31:0] run64 = 32'hFFFFFFFF;
    int          n_vec  = 0;
    int          n_fail = 0;
    int          waits;

    // Bit-serial reference: one input bit per step, LSB of the byte first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int k = 0; k < 8; k++) begin
            if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Scoreboards: every consumed result must match the oldest expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (i_reset_n && a32.m_valid === 1'b1 && a32.m_ready === 1'b1) begin
            e = (q32.size() > 0) ? q32.pop_front() : '{crc: 32'hxxxxxxxx, ok: 1'bx};
            check("sb32_crc", a32.m_crc, e.crc);
            check("sb32_ok", {31'b0, a32.m_crc_ok}, {31'b0, e.ok});
        end
        if (i_reset_n && a64.m_valid === 1'b1 && a64.m_ready === 1'b1) begin
            e = (q64.size() > 0) ? q64.pop_front() : '{crc: 32'hxxxxxxxx, ok: 1'bx};
            check("sb64_crc", a64.m_crc, e.crc);
            check("sb64_ok", {31'b0, a64.m_crc_ok}, {31'b0, e.ok});
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat's accept edge.
    task automatic send32(input logic [31:0] d, input logic [3:0] k, input logic last,
                          output int nw);
        a32.s_data = d; a32.s_keep = k; a32.s_last = last; a32.s_valid = 1'b1;
        nw = 0;
        @(negedge i_clk);
        while (a32.s_ready !== 1'b1 && nw < 50) begin
            @(negedge i_clk);
            nw++;
        end
        if (nw >= 50) check("send32_timeout", nw, 0);
        for (int j = 0; j < 4; j++) if (k[j]) run32 = crc_step(run32, d[8*j +: 8]);
        if (last) begin
            q32.push_back('{crc: ~run32, ok: (run32 == 32'hDEBB20E3)});
            run32 = 32'hFFFFFFFF;
        end
        @(posedge i_clk); #1;
    endtask

    task automatic send64(input logic [63:0] d, input logic [7:0] k, input logic last,
                          output int nw);
        a64.s_data = d; a64.s_keep = k; a64.s_last = last; a64.s_valid = 1'b1;
        nw = 0;
        @(negedge i_clk);
        while (a64.s_ready !== 1'b1 && nw < 50) begin
            @(negedge i_clk);
            nw++;
        end
        if (nw >= 50) check("send64_timeout", nw, 0);
        for (int j = 0; j < 8; j++) if (k[j]) run64 = crc_step(run64, d[8*j +: 8]);
        if (last) begin
            q64.push_back('{crc: ~run64, ok: (run64 == 32'hDEBB20E3)});
            run64 = 32'hFFFFFFFF;
        end
        @(posedge i_clk); #1;
    endtask

    // Idle with garbage on the qualified fields: must be ignored.
    task automatic idle32();
        a32.s_valid = 1'b0; a32.s_data = $urandom; a32.s_keep = 4'hF; a32.s_last = 1'b1;
    endtask

    task automatic idle64();
        a64.s_valid = 1'b0; a64.s_data = {$urandom, $urandom}; a64.s_keep = 8'hFF; a64.s_last = 1'b1;
    endtask

    task automatic gap();
        @(posedge i_clk); #1;
    endtask

    initial begin
        idle32(); idle64();
        a32.m_ready = 1'b1;
        a64.m_ready = 1'b1;

        // Reset values
        #1 i_reset_n = 1'b0;
        #2;
        check("rst_m_valid", {31'b0, a32.m_valid}, 32'd0);
        check("rst_m_crc", a32.m_crc, 32'd0);
        check("rst_m_crc_ok", {31'b0, a32.m_crc_ok}, 32'd0);
        check("rst_s_ready32", {31'b0, a32.s_ready}, 32'd0);
        check("rst_s_ready64", {31'b0, a64.s_ready}, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_reset_n = 1'b1;
        gap();
        check("post_rst_s_ready", {31'b0, a32.s_ready}, 32'd1);

        // "123456789", latency 1
        send32(32'h34333231, 4'hF, 1'b0, waits);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'h00000039, 4'h1, 1'b1, waits);
        check("check_m_valid", {31'b0, a32.m_valid}, 32'd1);
        check("check_crc", a32.m_crc, 32'hCBF43926);
        idle32();
        gap();
        check("check_consumed", {31'b0, a32.m_valid}, 32'd0);

        // Residue: "123456789" + FCS, then one flipped data bit
        send32(32'h34333231, 4'hF, 1'b0, waits);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'hF4392639, 4'hF, 1'b0, waits);
        send32(32'h000000CB, 4'h1, 1'b1, waits);
        check("residue_ok", {31'b0, a32.m_crc_ok}, 32'd1);
        send32(32'h34333230, 4'hF, 1'b0, waits);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'hF4392639, 4'hF, 1'b0, waits);
        send32(32'h000000CB, 4'h1, 1'b1, waits);
        check("residue_bad", {31'b0, a32.m_crc_ok}, 32'd0);
        idle32();
        gap();

        // Sparse keeps, an empty beat, and an empty closing beat
        send32(32'hAA32AA31, 4'b0101, 1'b0, waits);
        send32(32'h35AA3433, 4'b1011, 1'b0, waits);
        send32(32'hFFFFFFFF, 4'b0000, 1'b0, waits);
        send32(32'h39383736, 4'hF, 1'b0, waits);
        send32(32'hDEADBEEF, 4'b0000, 1'b1, waits);
        check("sparse_crc", a32.m_crc, 32'hCBF43926);
        idle32();
        gap();

        // Backpressure: result held, input stalled
        a32.m_ready = 1'b0;
        send32(32'h00000061, 4'h1, 1'b1, waits);
        check("bp_crc", a32.m_crc, 32'hE8B7BE43);
        idle32();
        repeat (5) begin
            @(negedge i_clk);
            check("bp_m_valid", {31'b0, a32.m_valid}, 32'd1);
            check("bp_crc_stable", a32.m_crc, 32'hE8B7BE43);
            check("bp_s_ready", {31'b0, a32.s_ready}, 32'd0);
        end
        gap();
        a32.m_ready = 1'b1;
        send32(32'h34333231, 4'hF, 1'b0, waits);
        check("bp_same_cycle", waits, 0);
        check("bp_released", {31'b0, a32.m_valid}, 32'd0);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'h00000039, 4'h1, 1'b1, waits);
        check("bp_next_crc", a32.m_crc, 32'hCBF43926);

        // Back-to-back frames with s_valid held high
        send32(32'h34333231, 4'hF, 1'b0, waits);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'h00000039, 4'h1, 1'b1, waits);
        check("b2b_crc1", a32.m_crc, 32'hCBF43926);
        send32(32'h34333231, 4'hF, 1'b0, waits);
        send32(32'h38373635, 4'hF, 1'b0, waits);
        send32(32'h00000039, 4'h1, 1'b1, waits);
        check("b2b_crc2", a32.m_crc, 32'hCBF43926);
        send32(32'h00000061, 4'h1, 1'b1, waits);
        check("b2b_single_a", a32.m_crc, 32'hE8B7BE43);
        send32(32'h00000062, 4'h1, 1'b1, waits);
        check("b2b_hold_valid", {31'b0, a32.m_valid}, 32'd1);
        idle32();
        gap();

        // Reset mid-frame
        send32(32'h34333231, 4'hF, 1'b0, waits);
        idle32();
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        check("midrst_m_valid", {31'b0, a32.m_valid}, 32'd0);
        check("midrst_s_ready", {31'b0, a32.s_ready}, 32'd0);
        check("midrst_m_crc", a32.m_crc, 32'd0);
        run32 = 32'hFFFFFFFF;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_reset_n = 1'b1;
        gap();
        send32(32'h00000061, 4'h1, 1'b1, waits);
        check("midrst_a_crc", a32.m_crc, 32'hE8B7BE43);
        idle32();
        gap();

        // 64-bit lanes
        send64(64'h0000000000000061, 8'h01, 1'b1, waits);
        check("w64_a_valid", {31'b0, a64.m_valid}, 32'd1);
        check("w64_a_crc", a64.m_crc, 32'hE8B7BE43);
        send64(64'h3837363534333231, 8'hFF, 1'b0, waits);
        send64(64'h0000000000000039, 8'h01, 1'b1, waits);
        check("w64_check_crc", a64.m_crc, 32'hCBF43926);
        send64(64'h5A00000000000031, 8'h81, 1'b0, waits);
        send64(64'h0102030405060700, 8'hFE, 1'b1, waits);
        idle64();
        repeat (3) gap();

        check("sb32_drain", q32.size(), 32'd0);
        check("sb64_drain", q64.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
